// File: rtl/hdec_j_pkg.sv
// Shared utility constants and the behavioural reference for the half-decoder.
package fpu_util_pkg;

   // Largest supported index width; the mask is 2**HDEC_MAX_N bits wide.
   localparam int unsigned HDEC_MAX_N = 8;

   // Reference thermometer decode for an n-bit index: bit i set iff i < x.
   function automatic logic [(1 << HDEC_MAX_N)-1:0] hdec_ref(input int unsigned n,
                                                             input int unsigned x);
      logic [(1 << HDEC_MAX_N)-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < (1 << n) && i < (1 << HDEC_MAX_N); i++) begin
         r[i] = (i < x);
      end
      return r;
   endfunction

endpackage

// File: rtl/hdec_j_if.sv
// Capture/result bundle for the registered half-decoder.
interface hdec_j_if #(
   parameter int unsigned N = 4
);
   logic                  in_valid;
   logic [N-1:0]          x;
   logic                  out_valid;
   logic [(1 << N)-1:0]   y;

   modport master (output in_valid, x, input out_valid, y);
   modport slave  (input in_valid, x, output out_valid, y);
endinterface

// File: rtl/hdec_j_core.sv
// Purely combinational recursive half-decoder: y[i] = (i < x), no per-bit compares.
module hdec_core #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]        x,
   output logic [(1 << N)-1:0] y
);
   localparam int unsigned HALF = 1 << (N - 1);

   if (N == 1) begin : g_leaf
      // Single-bit index: only bit 0 can ever be set.
      always_comb y = {1'b0, x[0]};
   end else begin : g_rec
      logic [HALF-1:0] sub;

      hdec_core #(.N(N - 1)) u_sub (
         .x (x[N-2:0]),
         .y (sub)
      );

      // Top index bit selects whether the lower half is saturated.
      always_comb begin
         y = '0;
         if (x[N-1]) y = {sub, {HALF{1'b1}}};
         else        y = {{HALF{1'b0}}, sub};
      end
   end
endmodule

// File: rtl/hdec_j.sv
// Half-decoder with a single registered output stage and valid flag.
module hdec_j
   import fpu_util_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   hdec_j_if.slave  bus
);
   localparam int unsigned W = 1 << N;

   logic [W-1:0] dec;

   hdec_core #(.N(N)) u_core (
      .x (bus.x),
      .y (dec)
   );

   // Load the decode on a valid cycle; hold the mask otherwise, valid tracks in_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.y         <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) bus.y <= dec;
      end
   end
endmodule

// File: tb/tb_hdec_j.sv
// Self-checking bench for hdec_j at N=4, N=1 and N=6.
module tb_hdec_j;
   import fpu_util_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hdec_j_if #(.N(4)) i4 ();
   hdec_j_if #(.N(1)) i1 ();
   hdec_j_if #(.N(6)) i6 ();

   hdec_j #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
   hdec_j #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
   hdec_j #(.N(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(i6.slave));

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   typedef struct {
      logic [3:0]  x;
      logic [15:0] y;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Thermometer mask from arithmetic: lowest x bits set.
   function automatic logic [255:0] model(input int unsigned x);
      logic [255:0] one;
      one = 256'd1;
      return (one << x) - one;
   endfunction

   logic [255:0] ref_v;
   logic [15:0]  held;

   initial begin
      vecs[0] = '{x: 4'b1000, y: 16'h00FF};
      vecs[1] = '{x: 4'b0001, y: 16'h0001};
      vecs[2] = '{x: 4'b0011, y: 16'h0007};
      vecs[3] = '{x: 4'b1100, y: 16'h0FFF};
      vecs[4] = '{x: 4'd0,    y: 16'h0000};
      vecs[5] = '{x: 4'd15,   y: 16'h7FFF};

      i4.in_valid = 1'b0; i4.x = '0;
      i1.in_valid = 1'b0; i1.x = '0;
      i6.in_valid = 1'b0; i6.x = '0;
      rst_n = 1'b0;
      #2;
      check("rst_y", 256'(i4.y), 256'd0);
      check("rst_ov", 256'(i4.out_valid), 256'd0);
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("idle_ov", 256'(i4.out_valid), 256'd0);

      // Directed and boundary vectors, each checked one cycle after capture.
      for (int i = 0; i < 6; i++) begin
         i4.in_valid = 1'b1;
         i4.x = vecs[i].x;
         tick();
         check($sformatf("vec%0d_y", i), 256'(i4.y), 256'(vecs[i].y));
         check($sformatf("vec%0d_ov", i), 256'(i4.out_valid), 256'd1);
      end

      // Valid / invalid / valid: mask held through the idle cycle.
      i4.in_valid = 1'b1; i4.x = 4'd5; tick();
      check("hs1_y", 256'(i4.y), 256'h1F);
      check("hs1_ov", 256'(i4.out_valid), 256'd1);
      i4.in_valid = 1'b0; i4.x = 4'd9; tick();
      check("hs2_y", 256'(i4.y), 256'h1F);
      check("hs2_ov", 256'(i4.out_valid), 256'd0);
      i4.in_valid = 1'b1; i4.x = 4'd2; tick();
      check("hs3_y", 256'(i4.y), 256'h3);
      check("hs3_ov", 256'(i4.out_valid), 256'd1);

      // Back-to-back 0..15 with no gaps in out_valid.
      for (int unsigned v = 0; v < 16; v++) begin
         i4.in_valid = 1'b1; i4.x = 4'(v);
         tick();
         check($sformatf("b2b%0d_y", v), 256'(i4.y), model(v));
         check($sformatf("b2b%0d_ov", v), 256'(i4.out_valid), 256'd1);
         check($sformatf("b2b%0d_pop", v), 256'($countones(i4.y)), 256'(v));
      end
      i4.in_valid = 1'b0;

      // N=1 sweep.
      i1.in_valid = 1'b1; i1.x = 1'b0; tick();
      check("n1_x0", 256'(i1.y), 256'd0);
      i1.x = 1'b1; tick();
      check("n1_x1", 256'(i1.y), 256'd1);
      check("n1_ov", 256'(i1.out_valid), 256'd1);
      i1.in_valid = 1'b0;

      // N=6 exhaustive against the package reference and popcount.
      for (int unsigned v = 0; v < 64; v++) begin
         i6.in_valid = 1'b1; i6.x = 6'(v);
         tick();
         ref_v = hdec_ref(6, v);
         check($sformatf("n6_%0d", v), 256'(i6.y), 256'(ref_v[63:0]));
         check($sformatf("n6_pop%0d", v), 256'($countones(i6.y)), 256'(v));
      end
      i6.in_valid = 1'b0;

      // Randomised N=4 traffic against the arithmetic model.
      held = i4.y;
      for (int k = 0; k < 300; k++) begin
         logic        v;
         int unsigned xx;
         v  = 1'($urandom_range(0, 1));
         xx = $urandom_range(0, 15);
         i4.in_valid = v; i4.x = 4'(xx);
         tick();
         if (v) held = 16'(model(xx));
         check("rnd_y", 256'(i4.y), 256'(held));
         check("rnd_ov", 256'(i4.out_valid), 256'(v));
         check("rnd_msb", 256'(i4.y[15]), 256'd0);
      end

      // Asynchronous reset mid-cycle with a non-zero mask loaded.
      i4.in_valid = 1'b1; i4.x = 4'd10;
      i6.in_valid = 1'b1; i6.x = 6'd40;
      tick();
      check("pre_rst_y", 256'(i4.y), 256'h03FF);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_y4", 256'(i4.y), 256'd0);
      check("arst_ov4", 256'(i4.out_valid), 256'd0);
      check("arst_y6", 256'(i6.y), 256'd0);
      tick();
      check("rst_hold_y", 256'(i4.y), 256'd0);
      check("rst_hold_ov", 256'(i4.out_valid), 256'd0);
      i4.in_valid = 1'b0; i6.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_y", 256'(i4.y), 256'd0);
      check("post_rst_ov", 256'(i4.out_valid), 256'd0);
      i4.in_valid = 1'b1; i4.x = 4'd7;
      tick();
      check("first_cap_y", 256'(i4.y), 256'h7F);
      check("first_cap_ov", 256'(i4.out_valid), 256'd1);
      i4.in_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/hdec_j.md
# hdec_j

Parameterised half-decoder (thermometer decoder) with a registered output stage. It converts an N-bit unsigned index `x` into a 2^N-bit mask in which exactly the lowest `x` bits are set. It sits in the floating-point unit's utility library and feeds normalisation and shift-mask logic, for example masking the sticky-bit range below a shift amount.

## Interface
- `N`, default 4: input index width; output width is 2^N. Legal range 1..8.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `in_valid`  input  1: `x` is valid this cycle and must be captured.
- `x`  input  N: unsigned index, value 0..2^N-1.
- `out_valid`  output  1: `y` holds the decode of a captured `x`.
- `y`  output  2^N: thermometer mask, registered.

## Operation
- Decode function: y[i] = 1 if and only if i < x (unsigned compare), for i = 0..2^N-1.
- Required values:
  - x=0 gives all zeros.
  - x=2^N-1 gives all ones except the MSB.
  - y[2^N-1] is always 0.
- The number of ones in `y` equals x. The ones are contiguous from bit 0.
- Decoding is recursive and uses no comparators per bit:
  - hdec(1): y = {1'b0, x[0]}.
  - hdec(n): the lower n-1 bits of x give the sub-mask L.
    - If x[n-1]=0: y = {zeros(2^(n-1)), L}.
    - If x[n-1]=1: y = {L, ones(2^(n-1))}.
- Capture:
  - When `in_valid`=1 on a rising edge: `y` is loaded with the decode of `x` and `out_valid` is set to 1.
  - When `in_valid`=0: `y` holds its previous value and `out_valid` is cleared to 0.
- No backpressure. Every valid input is accepted. Back-to-back valid inputs are legal and produce back-to-back outputs.

## Timing
- Latency: 1 cycle. A decode of `x` sampled at edge k is visible on `y` after edge k.
- Reset:
  - `rst_n`=0 immediately forces `y`=0 and `out_valid`=0, regardless of `clk`.
  - Both stay at 0 while `rst_n` is low.
- Reset release: the first capture happens on the first rising edge with `rst_n`=1 and `in_valid`=1.
- Reset mid-stream: any pending result is discarded. No output is generated for an `x` sampled in the cycle that reset asserts.
- The combinational path from `x` to the register input is log-depth, about N mux levels. There is no other combinational path from input to output.

## Structure
- Sub-module `hdec_core`:
  - Purely combinational recursive half-decoder, with parameter `N` and ports `x` and `y`.
  - Implemented with a generate recursion or a loop over levels.
  - `hdec_j` wraps it with the `in_valid`/`out_valid` register stage.
- Shared package `fpu_util_pkg` holds:
  - the `HDEC_MAX_N` constant, set to 8;
  - a `function automatic hdec_ref(x)`, the reference model (loop with y[i] = (i < x)) used by verification.
- No typedefs are required.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle with `y` nonzero. `y`=0 and `out_valid`=0 immediately, with no clock edge.
- Directed values, N=4, `in_valid`=1, checking one cycle later:
  - x=4'b1000 gives y=16'h00FF.
  - x=4'b0001 gives y=16'h0001.
  - x=4'b0011 gives y=16'h0007.
  - x=4'b1100 gives y=16'h0FFF.
- Boundaries, N=4:
  - x=0 gives y=16'h0000.
  - x=15 gives y=16'h7FFF.
  - The MSB is never set.
- Handshake:
  - Valid, invalid, valid sequence with x=5, then 9, then 2 gives `out_valid` 1,0,1.
  - `y` reads 0x001F, then holds 0x001F, then reads 0x0003.
- Exhaustive sweeps:
  - N=1: x=0 gives 2'b00; x=1 gives 2'b01.
  - N=6: all 64 values of x checked against `hdec_ref`.
  - popcount(y)==x for every value.
- Back-to-back: x = 0..15 applied on consecutive cycles. Each `y` matches the expected mask exactly one cycle after its input, with no gaps in `out_valid`.
